mem_access_load_unit: RTL and testbench
=======================================

Name: mem_access_load_unit

Overview:
- Memory-access-stage load engine that sits between the AGU and the load writeback/commit broadcast.
- Accepts address-generated load requests and issues them to the data cache. Tracks in-flight loads in order, then aligns and sign-extends the returned data.
- Produces one registered writeback beat (register read, ALU groups, AGU) and one commit beat (ROB) per completed load.

Parameters:
- XLEN, 32, data/address width
- ROB_IDX_W, 5, ROB index width
- PREG_W, 6, physical destination register index width
- DEPTH, 4, max in-flight loads (power of 2, >=2)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  pipeline squash; kills all in-flight loads
- req_valid  in  1  AGU load request valid
- req_ready  out  1  request accepted when req_valid&&req_ready
- req_addr  in  XLEN  effective byte address
- req_size  in  2  0=byte, 1=half, 2=word, 3=illegal
- req_unsigned  in  1  zero-extend instead of sign-extend
- req_rob_idx  in  ROB_IDX_W  ROB entry of the load
- req_prd  in  PREG_W  destination physical register
- dc_req_valid  out  1  dcache read request
- dc_req_ready  in  1  dcache accepts request
- dc_req_addr  out  XLEN  word-aligned address ({req_addr[XLEN-1:2],2'b00})
- dc_rsp_valid  in  1  dcache read data valid, strictly in request order
- dc_rsp_data  in  XLEN  read word
- wb_valid  out  1  load writeback valid
- wb_prd  out  PREG_W  writeback register
- wb_data  out  XLEN  aligned/extended load data
- commit_valid  out  1  load completion to ROB
- commit_rob_idx  out  ROB_IDX_W  completing ROB entry
- commit_exc  out  1  load address-misaligned exception

Behaviour:
- Reset: all outputs 0. Queue empty: head, tail and count = 0.
- Misaligned request: size==1 && addr[0]; size==2 && addr[1:0]!=0; or size==3.
- Aligned request:
  - dc_req_valid = req_valid && count<DEPTH && !flush.
  - req_ready = dc_req_ready && count<DEPTH && !flush.
- Misaligned request:
  - dc_req_valid = 0.
  - req_ready = (count==0) && !flush.
  - Accepted only when the queue is empty, so no dcache response can be pending.
- On accept, push entry {rob_idx, prd, size, unsigned, addr[1:0], exc, killed=0} at tail.
- Head pop:
  - head.exc=1: pops the cycle it is head.
  - head.exc=0: pops when dc_rsp_valid.
  - dc_rsp_valid with an empty queue is a protocol error; it is ignored.
- Full: count==DEPTH drives req_ready=0 even when a pop occurs the same cycle.
- Simultaneous push and pop below full: count is unchanged, and head and tail both advance modulo DEPTH.
- Alignment:
  - Shift dc_rsp_data right by 8*offset.
  - Byte uses bits [7:0]; half uses [15:0]; word uses the full value.
  - Sign-extend from the top bit unless unsigned.
- Output stage is registered; latency is dc_rsp_valid to wb_valid/commit_valid = 1 cycle.
  - Normal pop, not killed: wb_valid=1, commit_valid=1, commit_exc=0.
  - Exception pop, not killed: wb_valid=0, commit_valid=1, commit_exc=1, wb_data=0.
  - Outputs are single-cycle pulses; idle cycles drive valids to 0.
- Flush:
  - Sets killed on every queue entry, including the head popping that same cycle.
  - Clears the output register next cycle: all valids 0.
  - Blocks acceptance that cycle.
  - Killed entries still pop on their dcache response (the response is consumed and dropped) or immediately if exc. They produce no wb/commit.
  - New requests accepted after flush enqueue behind killed entries and complete normally in order.
- rst_n asserted mid-operation: queue and outputs clear immediately. The dcache is reset by the same rst_n, so no stale responses occur.

Optional Feature:
- Macro FALCO_LOAD_PERF_CNT_EN.
- When defined:
  - Adds outputs perf_load_cnt (32) and perf_stall_cnt (32), both reset to 0 and wrapping at 2^32.
  - perf_load_cnt increments on each non-killed commit_valid.
  - perf_stall_cnt increments each cycle where req_valid && !req_ready.
- When undefined: the ports and counters are absent; the rest of the behaviour is identical.

Test Plan:
- Word load addr=0x100, rob=3, prd=9; dcache rsp 0xDEADBEEF 2 cycles later -> next cycle wb_valid=1, wb_prd=9, wb_data=0xDEADBEEF, commit_rob_idx=3, commit_exc=0.
- Signed byte addr=0x103, rsp 0x80FF_1234 -> wb_data=0xFFFFFF80. Unsigned half addr=0x102, same rsp -> 0x000080FF.
- Half load addr=0x101, rob=7, queue empty -> no dc_req_valid; next cycle commit_valid=1, commit_rob_idx=7, commit_exc=1, wb_valid=0.
- Issue 4 loads with no responses -> req_ready=0 on a 5th. Return 4 responses back-to-back -> 4 consecutive wb beats in issue order, then req_ready=1.
- 2 loads in flight, flush; then 1 new load; 3 responses -> only the third produces wb/commit, with correct rob/prd.
- Assert rst_n low with 3 in flight -> all outputs 0 immediately, req_ready=1 after release with count=0.

Source files
------------

// File: rtl/mem_access_load_unit.sv
// Load engine between the AGU and the writeback/commit broadcast: issues word reads to the
// dcache, tracks in-flight loads in order, aligns/extends the data. Optional perf counters: FALCO_LOAD_PERF_CNT_EN.
module mem_access_load_unit #(
  parameter int XLEN      = 32,
  parameter int ROB_IDX_W = 5,
  parameter int PREG_W    = 6,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [XLEN-1:0]      req_addr,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [ROB_IDX_W-1:0] req_rob_idx,
  input  logic [PREG_W-1:0]    req_prd,
  output logic                 dc_req_valid,
  input  logic                 dc_req_ready,
  output logic [XLEN-1:0]      dc_req_addr,
  input  logic                 dc_rsp_valid,
  input  logic [XLEN-1:0]      dc_rsp_data,
  output logic                 wb_valid,
  output logic [PREG_W-1:0]    wb_prd,
  output logic [XLEN-1:0]      wb_data,
  output logic                 commit_valid,
  output logic [ROB_IDX_W-1:0] commit_rob_idx,
  output logic                 commit_exc
`ifdef FALCO_LOAD_PERF_CNT_EN
  ,
  output logic [31:0]          perf_load_cnt,
  output logic [31:0]          perf_stall_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [PREG_W-1:0]    prd;
    logic [1:0]           size;
    logic                 uns;
    logic [1:0]           off;
    logic                 exc;
    logic                 killed;
  } entry_t;

  entry_t               mem_q [DEPTH];
  entry_t               mem_d [DEPTH];
  logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;

  logic                 wb_valid_q, wb_valid_d;
  logic [PREG_W-1:0]    wb_prd_q, wb_prd_d;
  logic [XLEN-1:0]      wb_data_q, wb_data_d;
  logic                 commit_valid_q, commit_valid_d;
  logic [ROB_IDX_W-1:0] commit_rob_idx_q, commit_rob_idx_d;
  logic                 commit_exc_q, commit_exc_d;

  logic                 misaligned, full, empty, push, pop, kill;
  entry_t               head_e;
  logic [XLEN-1:0]      shifted, aligned;

  assign misaligned = (req_size == 2'd1 && req_addr[0]) ||
                      (req_size == 2'd2 && req_addr[1:0] != 2'b00) ||
                      (req_size == 2'd3);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // Misaligned loads only enter an empty queue, so no dcache response can overtake them.
  assign req_ready    = misaligned ? (empty && !flush) : (dc_req_ready && !full && !flush);
  assign dc_req_valid = !misaligned && req_valid && !full && !flush;
  assign dc_req_addr  = {req_addr[XLEN-1:2], 2'b00};
  assign push         = req_valid && req_ready;

  assign head_e = mem_q[head_q];
  assign pop    = !empty && (head_e.exc || dc_rsp_valid);
  assign kill   = head_e.killed || flush;

  assign shifted = dc_rsp_data >> {head_e.off, 3'b000};

  always_comb begin
    aligned = shifted;
    case (head_e.size)
      2'd0:    aligned = {{(XLEN-8){shifted[7] & ~head_e.uns}}, shifted[7:0]};
      2'd1:    aligned = {{(XLEN-16){shifted[15] & ~head_e.uns}}, shifted[15:0]};
      default: aligned = shifted;
    endcase
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (flush) mem_d[i].killed = 1'b1;
    end
    if (push) begin
      mem_d[tail_q] = '{rob_idx: req_rob_idx, prd: req_prd, size: req_size,
                        uns: req_unsigned, off: req_addr[1:0], exc: misaligned,
                        killed: 1'b0};
    end
    head_d  = pop  ? head_q + PTR_W'(1) : head_q;
    tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Killed pops (including the one caught by flush this cycle) are consumed silently.
  always_comb begin
    commit_valid_d   = pop && !kill;
    wb_valid_d       = commit_valid_d && !head_e.exc;
    commit_exc_d     = commit_valid_d && head_e.exc;
    commit_rob_idx_d = commit_valid_d ? head_e.rob_idx : '0;
    wb_prd_d         = wb_valid_d ? head_e.prd : '0;
    wb_data_d        = wb_valid_d ? aligned : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
      wb_valid_q       <= 1'b0;
      wb_prd_q         <= '0;
      wb_data_q        <= '0;
      commit_valid_q   <= 1'b0;
      commit_rob_idx_q <= '0;
      commit_exc_q     <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      head_q           <= head_d;
      tail_q           <= tail_d;
      count_q          <= count_d;
      wb_valid_q       <= wb_valid_d;
      wb_prd_q         <= wb_prd_d;
      wb_data_q        <= wb_data_d;
      commit_valid_q   <= commit_valid_d;
      commit_rob_idx_q <= commit_rob_idx_d;
      commit_exc_q     <= commit_exc_d;
    end
  end

  assign wb_valid       = wb_valid_q;
  assign wb_prd         = wb_prd_q;
  assign wb_data        = wb_data_q;
  assign commit_valid   = commit_valid_q;
  assign commit_rob_idx = commit_rob_idx_q;
  assign commit_exc     = commit_exc_q;

`ifdef FALCO_LOAD_PERF_CNT_EN
  logic [31:0] perf_load_cnt_q, perf_load_cnt_d;
  logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;

  always_comb begin
    perf_load_cnt_d  = perf_load_cnt_q + 32'(commit_valid_q);
    perf_stall_cnt_d = perf_stall_cnt_q + 32'(req_valid && !req_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_load_cnt_q  <= '0;
      perf_stall_cnt_q <= '0;
    end else begin
      perf_load_cnt_q  <= perf_load_cnt_d;
      perf_stall_cnt_q <= perf_stall_cnt_d;
    end
  end

  assign perf_load_cnt  = perf_load_cnt_q;
  assign perf_stall_cnt = perf_stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_access_load_unit.sv
// Directed bench for mem_access_load_unit: a reference queue predicts handshakes, and a
// scoreboard of expected writeback/commit beats is checked one cycle after each pop.
module tb_mem_access_load_unit;

  logic        clk = 1'b0;
  logic        rst_n, flush, req_valid, req_unsigned, dc_req_ready, dc_rsp_valid;
  logic [31:0] req_addr, dc_rsp_data;
  logic [1:0]  req_size;
  logic [4:0]  req_rob_idx;
  logic [5:0]  req_prd;
  logic        req_ready, dc_req_valid, wb_valid, commit_valid, commit_exc;
  logic [31:0] dc_req_addr, wb_data;
  logic [5:0]  wb_prd;
  logic [4:0]  commit_rob_idx;
`ifdef FALCO_LOAD_PERF_CNT_EN
  logic [31:0] perf_load_cnt, perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  mem_access_load_unit dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_rob_idx(req_rob_idx),
    .req_prd(req_prd), .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready),
    .dc_req_addr(dc_req_addr), .dc_rsp_valid(dc_rsp_valid), .dc_rsp_data(dc_rsp_data),
    .wb_valid(wb_valid), .wb_prd(wb_prd), .wb_data(wb_data),
    .commit_valid(commit_valid), .commit_rob_idx(commit_rob_idx), .commit_exc(commit_exc)
`ifdef FALCO_LOAD_PERF_CNT_EN
    , .perf_load_cnt(perf_load_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [4:0]  rob;
    logic [5:0]  prd;
    logic        exc;
    logic        killed;
  } pend_t;

  typedef struct {
    logic        wb;
    logic [5:0]  prd;
    logic [31:0] data;
    logic [4:0]  rob;
    logic        exc;
  } exp_t;

  pend_t pend_q[$];
  exp_t  exp_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic is_mis(input logic [31:0] a, input logic [1:0] s);
    case (s)
      2'd0:    return 1'b0;
      2'd1:    return a[0];
      2'd2:    return a[1:0] != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] load_value(input pend_t p, input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[8*p.addr[1:0] +: 8];
    h = d[8*p.addr[1:0] +: 16];
    case (p.size)
      2'd0:    return p.uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'd1:    return p.uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: return d;
    endcase
  endfunction

  task automatic drive_req(input logic [31:0] a, input logic [1:0] s, input logic u,
                           input logic [4:0] rob, input logic [5:0] prd);
    req_valid = 1'b1; req_addr = a; req_size = s; req_unsigned = u;
    req_rob_idx = rob; req_prd = prd;
  endtask

  task automatic idle();
    req_valid = 1'b0; dc_rsp_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic rsp(input logic [31:0] d);
    dc_rsp_valid = 1'b1; dc_rsp_data = d;
  endtask

  // One clock: check handshakes against the reference, advance it, then check registered outputs.
  task automatic cycle();
    logic  mis, exp_ready, exp_dcv;
    pend_t h;
    exp_t  e;
    #1;
    mis       = is_mis(req_addr, req_size);
    exp_ready = mis ? (pend_q.size() == 0 && !flush)
                    : (dc_req_ready && pend_q.size() < 4 && !flush);
    exp_dcv   = !mis && req_valid && pend_q.size() < 4 && !flush;
    chk("req_ready", {31'b0, req_ready}, {31'b0, exp_ready});
    chk("dc_req_valid", {31'b0, dc_req_valid}, {31'b0, exp_dcv});
    if (exp_dcv) chk("dc_req_addr", dc_req_addr, {req_addr[31:2], 2'b00});
    if (pend_q.size() > 0 && (pend_q[0].exc || dc_rsp_valid)) begin
      h = pend_q.pop_front();
      if (!(h.killed || flush)) begin
        e.wb   = !h.exc;
        e.prd  = h.prd;
        e.rob  = h.rob;
        e.exc  = h.exc;
        e.data = h.exc ? 32'h0 : load_value(h, dc_rsp_data);
        exp_q.push_back(e);
      end
    end
    if (flush) foreach (pend_q[i]) pend_q[i].killed = 1'b1;
    if (req_valid && exp_ready)
      pend_q.push_back('{req_addr, req_size, req_unsigned, req_rob_idx, req_prd, mis, 1'b0});
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("commit_valid", {31'b0, commit_valid}, 32'd1);
      chk("commit_rob_idx", {27'b0, commit_rob_idx}, {27'b0, e.rob});
      chk("commit_exc", {31'b0, commit_exc}, {31'b0, e.exc});
      chk("wb_valid", {31'b0, wb_valid}, {31'b0, e.wb});
      if (e.wb) chk("wb_prd", {26'b0, wb_prd}, {26'b0, e.prd});
      chk("wb_data", wb_data, e.data);
    end else begin
      chk("idle_commit_valid", {31'b0, commit_valid}, 32'd0);
      chk("idle_wb_valid", {31'b0, wb_valid}, 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; req_addr = '0; req_size = '0;
    req_unsigned = 1'b0; req_rob_idx = '0; req_prd = '0; dc_req_ready = 1'b0;
    dc_rsp_valid = 1'b0; dc_rsp_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_dc_req_valid", {31'b0, dc_req_valid}, 32'd0);
    chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst_commit_valid", {31'b0, commit_valid}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_commit_rob_idx", {27'b0, commit_rob_idx}, 32'd0);
    rst_n = 1'b1;
    dc_req_ready = 1'b1;
    cycle();

    // Word load, response two cycles after issue
    drive_req(32'h100, 2'd2, 1'b0, 5'd3, 6'd9); cycle();
    idle(); cycle();
    rsp(32'hDEADBEEF); cycle();
    idle(); cycle();

    // Sub-word alignment and extension
    drive_req(32'h103, 2'd0, 1'b0, 5'd4, 6'd10); cycle();
    idle(); rsp(32'h80FF_1234); cycle();
    drive_req(32'h102, 2'd1, 1'b1, 5'd5, 6'd11); cycle();
    idle(); rsp(32'h80FF_1234); cycle();
    drive_req(32'h100, 2'd1, 1'b0, 5'd6, 6'd12); cycle();
    idle(); rsp(32'h1234_8001); cycle();
    drive_req(32'h101, 2'd0, 1'b1, 5'd1, 6'd13); cycle();
    idle(); rsp(32'h1234_F501); cycle();
    idle(); cycle();

    // dcache stalls the request
    dc_req_ready = 1'b0;
    drive_req(32'h104, 2'd2, 1'b0, 5'd2, 6'd14); cycle();
    dc_req_ready = 1'b1; idle(); cycle();

    // Misaligned half with empty queue; illegal size
    drive_req(32'h101, 2'd1, 1'b0, 5'd7, 6'd15); cycle();
    idle(); cycle();
    idle(); cycle();
    drive_req(32'h200, 2'd3, 1'b0, 5'd8, 6'd16); cycle();
    idle(); cycle();

    // Misaligned request blocked while a load is in flight
    drive_req(32'h300, 2'd2, 1'b0, 5'd9, 6'd17); cycle();
    drive_req(32'h302, 2'd2, 1'b0, 5'd10, 6'd18); cycle();
    idle(); rsp(32'hCAFE_F00D); cycle();
    idle(); cycle();

    // Stray response with empty queue is ignored
    rsp(32'h1111_2222); cycle();
    idle(); cycle();

    // Fill the queue, stall a 5th, drain back-to-back
    for (int i = 0; i < 4; i++) begin
      drive_req(32'h400 + 32'(4 * i), 2'd2, 1'b0, 5'(8 + i), 6'(20 + i)); cycle();
    end
    drive_req(32'h500, 2'd2, 1'b0, 5'd12, 6'd24); cycle();
    rsp(32'hA000_0000); cycle();
    req_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      rsp(32'hA000_0000 + 32'(i)); cycle();
    end
    idle(); cycle();
    drive_req(32'h500, 2'd2, 1'b0, 5'd12, 6'd24); cycle();
    idle(); rsp(32'hB0B0_B0B0); cycle();
    idle(); cycle();

    // Flush with two in flight, then one new load
    drive_req(32'h600, 2'd2, 1'b0, 5'd13, 6'd25); cycle();
    drive_req(32'h604, 2'd2, 1'b0, 5'd14, 6'd26); cycle();
    idle(); flush = 1'b1; req_valid = 1'b1; cycle();
    idle(); drive_req(32'h608, 2'd0, 1'b0, 5'd15, 6'd30); cycle();
    idle(); rsp(32'h0000_0011); cycle();
    rsp(32'h0000_0022); cycle();
    rsp(32'h0000_0083); cycle();
    idle(); cycle();

    // Flush in the same cycle as the head's response
    drive_req(32'h700, 2'd2, 1'b0, 5'd16, 6'd31); cycle();
    idle(); rsp(32'h7777_7777); flush = 1'b1; cycle();
    idle(); cycle();

    // Asynchronous reset with loads in flight
    for (int i = 0; i < 3; i++) begin
      drive_req(32'h800 + 32'(4 * i), 2'd2, 1'b0, 5'(17 + i), 6'(40 + i)); cycle();
    end
    idle(); rsp(32'h5555_AAAA); cycle();
    idle();
    rst_n = 1'b0;
    #1;
    chk("arst_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("arst_commit_valid", {31'b0, commit_valid}, 32'd0);
    chk("arst_wb_data", wb_data, 32'd0);
    chk("arst_wb_prd", {26'b0, wb_prd}, 32'd0);
    chk("arst_commit_rob_idx", {27'b0, commit_rob_idx}, 32'd0);
    pend_q.delete();
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_req(32'h901, 2'd1, 1'b0, 5'd20, 6'd50); cycle();
    idle(); cycle();
    drive_req(32'h904, 2'd2, 1'b0, 5'd21, 6'd51); cycle();
    idle(); rsp(32'h1357_9BDF); cycle();
    idle(); cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
